// File: rtl/clk_mgr_pkg.sv
// Shared types and default constants for the clock-enable / reset-sequencing manager.
package clk_mgr_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } clk_mgr_state_e;

   localparam int unsigned DEF_NUM_CH          = 4;
   localparam int unsigned DEF_DIV_W           = 8;
   localparam int unsigned DEF_LOCK_STABLE_CYC = 16;
   localparam int unsigned DEF_RST_GAP_CYC     = 4;

   // Width of a counter that must hold the values 0..n-1 (never narrower than 1 bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser bringing an asynchronous level into the sys_clk_i domain.
module bit_sync (
   input  logic sys_clk_i,
   input  logic sys_rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: non-blocking assignments so the second flop samples the first flop's pre-edge value.
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/clk_en_rst_manager.sv
// Waits for a stable PLL lock, releases per-channel resets one by one, then
// generates per-channel clock-enable pulses from programmable divide ratios.
module clk_en_rst_manager
   import clk_mgr_pkg::*;
#(
   parameter int unsigned NUM_CH          = DEF_NUM_CH,
   parameter int unsigned DIV_W           = DEF_DIV_W,
   parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
   parameter int unsigned RST_GAP_CYC     = DEF_RST_GAP_CYC
) (
   input  logic                    sys_clk_i,
   input  logic                    sys_rst_i,
   input  logic                    pll_locked_i,
   input  logic                    sw_rst_i,
   input  logic                    cfg_load_i,
   input  logic [NUM_CH*DIV_W-1:0] div_ratio_i,
   output logic [NUM_CH-1:0]       clk_en_o,
   output logic [NUM_CH-1:0]       rstn_o,
   output logic                    ready_o
);

   localparam int unsigned STB_W = cnt_w(LOCK_STABLE_CYC);
   localparam int unsigned GAP_W = cnt_w(RST_GAP_CYC);
   localparam int unsigned IDX_W = cnt_w(NUM_CH);

   localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RST_GAP_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

   clk_mgr_state_e    state_q, state_d;
   logic [STB_W-1:0]  stable_q, stable_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [NUM_CH-1:0] rstn_q, rstn_d;
   logic [NUM_CH-1:0] clk_en_q, clk_en_d;
   logic              ready_q, ready_d;
   logic [DIV_W-1:0]  ratio_q [NUM_CH];
   logic [DIV_W-1:0]  ratio_d [NUM_CH];
   logic [DIV_W-1:0]  cnt_q   [NUM_CH];
   logic [DIV_W-1:0]  cnt_d   [NUM_CH];

   logic locked_s;
   logic abort;

   // Terminal count of a divider; ratios 0 and 1 both mean "every cycle".
   function automatic logic [DIV_W-1:0] last_cnt(input logic [DIV_W-1:0] r);
      return (r <= DIV_W'(1)) ? '0 : r - 1'b1;
   endfunction

   bit_sync u_lock_sync (
      .sys_clk_i (sys_clk_i),
      .sys_rst_i (sys_rst_i),
      .d_i       (pll_locked_i),
      .q_o       (locked_s)
   );

   assign abort = (state_q != WAIT_LOCK) && (!locked_s || sw_rst_i);

   always_comb begin
      // NOTE: every variable gets a default first, so no branch can infer a latch.
      state_d  = state_q;
      stable_d = stable_q;
      gap_d    = gap_q;
      idx_d    = idx_q;
      rstn_d   = rstn_q;
      ready_d  = 1'b0;

      unique case (state_q)
         WAIT_LOCK: begin
            stable_d = '0;
            gap_d    = '0;
            idx_d    = '0;
            rstn_d   = '0;
            if (locked_s && !sw_rst_i) state_d = STABLE;
         end
         STABLE: begin
            if (stable_q == STB_LAST) begin
               state_d  = RELEASE;
               stable_d = '0;
               gap_d    = '0;
               idx_d    = '0;
            end else begin
               stable_d = stable_q + 1'b1;
            end
         end
         RELEASE: begin
            if (gap_q == '0) rstn_d[idx_q] = 1'b1;
            if (gap_q == GAP_LAST) begin
               gap_d = '0;
               if (idx_q == IDX_LAST) state_d = RUN;
               else                   idx_d   = idx_q + 1'b1;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         RUN:     ready_d = 1'b1;
         default: state_d = WAIT_LOCK;
      endcase

      // Lock loss or software reset overrides whatever the sequence was doing.
      if (abort) begin
         state_d  = WAIT_LOCK;
         stable_d = '0;
         gap_d    = '0;
         idx_d    = '0;
         rstn_d   = '0;
         ready_d  = 1'b0;
      end
   end

   // Dividers restart from 0 on a ratio load; the pulse is suppressed on that edge.
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         ratio_d[k]  = cfg_load_i ? div_ratio_i[k*DIV_W +: DIV_W] : ratio_q[k];
         cnt_d[k]    = '0;
         clk_en_d[k] = 1'b0;
         if (rstn_q[k] && !abort && !cfg_load_i) begin
            clk_en_d[k] = (cnt_q[k] == last_cnt(ratio_q[k]));
            cnt_d[k]    = clk_en_d[k] ? '0 : cnt_q[k] + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state_q  <= WAIT_LOCK;
         stable_q <= '0;
         gap_q    <= '0;
         idx_q    <= '0;
         rstn_q   <= '0;
         clk_en_q <= '0;
         ready_q  <= 1'b0;
         // NOTE: the ratio array is a small register file, not a RAM, so it is reset to a safe ratio of 1.
         for (int k = 0; k < NUM_CH; k++) begin
            ratio_q[k] <= DIV_W'(1);
            cnt_q[k]   <= '0;
         end
      end else begin
         state_q  <= state_d;
         stable_q <= stable_d;
         gap_q    <= gap_d;
         idx_q    <= idx_d;
         rstn_q   <= rstn_d;
         clk_en_q <= clk_en_d;
         ready_q  <= ready_d;
         ratio_q  <= ratio_d;
         cnt_q    <= cnt_d;
      end
   end

   assign clk_en_o = clk_en_q;
   assign rstn_o   = rstn_q;
   assign ready_o  = ready_q;

endmodule

// File: tb/tb_clk_en_rst_manager.sv
// Scoreboard bench: an event-time reference model predicts the outputs after every
// edge, a monitor compares them on the falling edge; directed scenarios add timing checks.
module tb_clk_en_rst_manager;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int L  = 16;
   localparam int G  = 4;

   logic            sys_clk_i = 1'b0;
   logic            sys_rst_i;
   logic            pll_locked_i;
   logic            sw_rst_i;
   logic            cfg_load_i;
   logic [N*DW-1:0] div_ratio_i;
   logic [N-1:0]    clk_en_o;
   logic [N-1:0]    rstn_o;
   logic            ready_o;

   clk_en_rst_manager #(
      .NUM_CH          (N),
      .DIV_W           (DW),
      .LOCK_STABLE_CYC (L),
      .RST_GAP_CYC     (G)
   ) dut (
      .sys_clk_i    (sys_clk_i),
      .sys_rst_i    (sys_rst_i),
      .pll_locked_i (pll_locked_i),
      .sw_rst_i     (sw_rst_i),
      .cfg_load_i   (cfg_load_i),
      .div_ratio_i  (div_ratio_i),
      .clk_en_o     (clk_en_o),
      .rstn_o       (rstn_o),
      .ready_o      (ready_o)
   );

   always #5 sys_clk_i = ~sys_clk_i;

   typedef struct packed {
      logic [N-1:0] en;
      logic [N-1:0] rstn;
      logic         rdy;
   } obs_t;

   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model. The sequence is described by event times: m_t0 is the edge on
   // which a lock was first seen stable (STABLE entry); channel k is released at
   // m_t0+L+1+k*G and ready follows at m_t0+L+1+N*G. Dividers pulse every r cycles
   // counted from the later of the release edge and the last ratio-load edge.
   int m_t0      = -1;
   int last_load = -1;
   int ratio_m [N];
   bit hist [int];

   initial for (int k = 0; k < N; k++) ratio_m[k] = 1;

   always @(posedge sys_clk_i) begin : ref_model
      obs_t e;
      bit   lk;
      int   rise, anchor, r;
      cyc++;
      e = '0;
      if (sys_rst_i) begin
         hist[cyc] = 1'b0;
         m_t0      = -1;
         last_load = -1;
         for (int k = 0; k < N; k++) ratio_m[k] = 1;
      end else begin
         hist[cyc] = pll_locked_i;
         // Lock as seen by the FSM at this edge: the pin value two edges earlier.
         lk = hist.exists(cyc - 2) ? hist[cyc - 2] : 1'b0;
         if (m_t0 < 0) begin
            if (lk && !sw_rst_i) m_t0 = cyc;
         end else if (!lk || sw_rst_i) begin
            m_t0 = -1;
         end
         if (cfg_load_i) begin
            for (int k = 0; k < N; k++) ratio_m[k] = int'(div_ratio_i[k*DW +: DW]);
            last_load = cyc;
         end
         if (m_t0 >= 0) begin
            for (int k = 0; k < N; k++) begin
               rise       = m_t0 + L + 1 + k * G;
               e.rstn[k]  = (cyc >= rise);
               anchor     = (rise > last_load) ? rise : last_load;
               r          = (ratio_m[k] <= 1) ? 1 : ratio_m[k];
               e.en[k]    = (cyc > anchor) && (((cyc - anchor) % r) == 0);
            end
            e.rdy = (cyc >= m_t0 + L + 1 + N * G);
         end
      end
      exp_q.push_back(e);
   end

   // Monitor: one prediction per edge, compared mid-cycle. An asynchronous reset
   // asserted after the edge forces the expectation to all-zero.
   always @(negedge sys_clk_i) begin : monitor
      obs_t e;
      if (exp_q.size() == 0) begin
         check("scoreboard_underflow", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         if (sys_rst_i) e = '0;
         check("outputs{en,rstn,rdy}", 32'({clk_en_o, rstn_o, ready_o}), 32'(e));
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   int pc [N];
   int rise_t [N];
   int rdy_t;

   task automatic count_pulses(input int n);
      for (int k = 0; k < N; k++) pc[k] = 0;
      repeat (n) begin
         @(negedge sys_clk_i);
         for (int k = 0; k < N; k++) if (clk_en_o[k]) pc[k]++;
      end
   endtask

   // Waits (bounded) for rstn_o[sel], or ready_o when sel == N.
   task automatic wait_for(input int sel, input int max_cyc, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge sys_clk_i);
         seen = (sel < N) ? rstn_o[sel] : ready_o;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   initial begin : stimulus
      bit found;
      int g_hi;

      sys_rst_i    = 1'b1;
      pll_locked_i = 1'b0;
      sw_rst_i     = 1'b0;
      cfg_load_i   = 1'b0;
      div_ratio_i  = '0;

      repeat (3) @(negedge sys_clk_i);
      check("reset_outputs", 32'({clk_en_o, rstn_o, ready_o}), 32'd0);
      sys_rst_i = 1'b0;

      // Scenario 1: lock at edge 10. Two sync edges, STABLE entered at edge 12,
      // 16 stable cycles, RELEASE at 28, rstn_o[0] at edge 29 = 10 + 2 + 16 + 1.
      while (cyc < 9) @(negedge sys_clk_i);
      pll_locked_i = 1'b1;
      for (int k = 0; k < N; k++) rise_t[k] = -1;
      rdy_t = -1;
      repeat (60) begin
         @(negedge sys_clk_i);
         for (int k = 0; k < N; k++) if (rise_t[k] < 0 && rstn_o[k]) rise_t[k] = cyc;
         if (rdy_t < 0 && ready_o) rdy_t = cyc;
      end
      check("rstn0_latency", 32'(rise_t[0] - 10), 32'(2 + L + 1));
      for (int k = 1; k < N; k++) check("rstn_k_gap", 32'(rise_t[k] - rise_t[0]), 32'(k * G));
      check("ready_after_last_rstn", 32'(rdy_t - rise_t[N-1]), 32'(G));

      // Scenario 2: ratios {1,2,5,0} loaded in RUN.
      div_ratio_i = {8'd0, 8'd5, 8'd2, 8'd1};
      cfg_load_i  = 1'b1;
      @(negedge sys_clk_i);
      cfg_load_i = 1'b0;
      count_pulses(30);
      check("ratio1_pulses", 32'(pc[0]), 32'd30);
      check("ratio2_pulses", 32'(pc[1]), 32'd15);
      check("ratio5_pulses", 32'(pc[2]), 32'd6);
      check("ratio0_pulses", 32'(pc[3]), 32'd30);

      // Scenario 3: one-cycle lock drop right after rstn_o[2] is released.
      sw_rst_i = 1'b1;
      @(negedge sys_clk_i);
      sw_rst_i = 1'b0;
      wait_for(2, 100, "reach_rstn2");
      pll_locked_i = 1'b0;
      @(negedge sys_clk_i);
      pll_locked_i = 1'b1;
      @(negedge sys_clk_i);
      check("rstn2_before_abort", 32'(rstn_o[2]), 32'd1);
      @(negedge sys_clk_i);
      check("abort_clears", 32'({clk_en_o, rstn_o, ready_o}), 32'd0);
      wait_for(N, 120, "relock_ready");

      // Scenario 4: glitch reaching the FSM at stable count 10.
      sw_rst_i = 1'b1;
      @(negedge sys_clk_i);
      sw_rst_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge sys_clk_i);
         found = (m_t0 >= 0) && (cyc == m_t0 + 8);
      end
      check("reach_stable_8", 32'(found), 32'd1);
      pll_locked_i = 1'b0;
      @(negedge sys_clk_i);
      pll_locked_i = 1'b1;
      g_hi = cyc + 1;
      rise_t[0] = -1;
      for (int i = 0; i < 80 && rise_t[0] < 0; i++) begin
         @(negedge sys_clk_i);
         if (rstn_o[0]) rise_t[0] = cyc;
      end
      check("glitch_restart_latency", 32'(rise_t[0] - g_hi), 32'(2 + L + 1));
      wait_for(N, 120, "glitch_ready");

      // Scenario 5: software reset together with a ratio-3 load.
      div_ratio_i = {N{8'd3}};
      cfg_load_i  = 1'b1;
      sw_rst_i    = 1'b1;
      @(negedge sys_clk_i);
      cfg_load_i = 1'b0;
      sw_rst_i   = 1'b0;
      check("swrst_load_clears", 32'({clk_en_o, rstn_o, ready_o}), 32'd0);
      wait_for(N, 120, "swrst_ready");
      count_pulses(30);
      for (int k = 0; k < N; k++) check("ratio3_pulses", 32'(pc[k]), 32'd10);

      // Scenario 6: asynchronous reset between edges while running.
      @(posedge sys_clk_i);
      #2;
      sys_rst_i = 1'b1;
      #1;
      check("async_rst_rstn", 32'(rstn_o), 32'd0);
      check("async_rst_en", 32'(clk_en_o), 32'd0);
      check("async_rst_ready", 32'(ready_o), 32'd0);
      repeat (3) @(negedge sys_clk_i);
      sys_rst_i = 1'b0;
      wait_for(N, 120, "post_rst_ready");
      count_pulses(20);
      for (int k = 0; k < N; k++) check("ratio_reset_pulses", 32'(pc[k]), 32'd20);

      // Randomised mix of loads, software resets and lock glitches.
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0: repeat ($urandom_range(5, 40)) @(negedge sys_clk_i);
            1: begin
               for (int k = 0; k < N; k++) div_ratio_i[k*DW +: DW] = 8'($urandom_range(0, 7));
               cfg_load_i = 1'b1;
               @(negedge sys_clk_i);
               cfg_load_i = 1'b0;
            end
            2: begin
               sw_rst_i = 1'b1;
               repeat ($urandom_range(1, 3)) @(negedge sys_clk_i);
               sw_rst_i = 1'b0;
            end
            3: begin
               pll_locked_i = 1'b0;
               repeat ($urandom_range(1, 3)) @(negedge sys_clk_i);
               pll_locked_i = 1'b1;
            end
            default: begin
               for (int k = 0; k < N; k++) div_ratio_i[k*DW +: DW] = 8'($urandom_range(0, 7));
               cfg_load_i = 1'b1;
               sw_rst_i   = 1'b1;
               @(negedge sys_clk_i);
               cfg_load_i = 1'b0;
               sw_rst_i   = 1'b0;
            end
         endcase
         repeat ($urandom_range(1, 30)) @(negedge sys_clk_i);
      end
      repeat (60) @(negedge sys_clk_i);

      @(posedge sys_clk_i);
      @(negedge sys_clk_i);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_en_rst_manager.md
CLK_EN_RST_MANAGER -- requirements
Module: clk_en_rst_manager

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of output channels (1..16).
REQ-002 The block SHALL have parameter DIV_W, default 8: width of each divide ratio.
REQ-003 The block SHALL have parameter LOCK_STABLE_CYC, default 16: cycles synchronised lock must stay high before reset release (>=1).
REQ-004 The block SHALL have parameter RST_GAP_CYC, default 4: cycles between consecutive channel reset releases (>=1).

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have the port sys_clk_i, input, 1: the single clock.
REQ-006 The block SHALL have the port sys_rst_i, input, 1: reset, asynchronous and active-high.
REQ-007 The block SHALL have the port pll_locked_i, input, 1: asynchronous PLL lock indication.
REQ-008 The block SHALL have the port sw_rst_i, input, 1: synchronous software reset request, one-cycle pulse or level.
REQ-009 The block SHALL have the port cfg_load_i, input, 1: load div_ratio_i into the ratio registers.
REQ-010 The block SHALL have the port div_ratio_i, input, NUM_CH*DIV_W: per-channel divide ratios, with channel k in bits [k*DIV_W +: DIV_W].
REQ-011 The block SHALL have the port clk_en_o, output, NUM_CH: per-channel clock-enable pulses.
REQ-012 The block SHALL have the port rstn_o, output, NUM_CH: per-channel active-low synchronous resets.
REQ-013 The block SHALL have the port ready_o, output, 1: high when all channels are released (RUN state).

Function
REQ-014 pll_locked_i SHALL pass through a 2-flop synchroniser; locked_s is its output, with 2 cycles of latency.
REQ-015 The FSM SHALL have states WAIT_LOCK, STABLE, RELEASE, RUN.
REQ-016 In WAIT_LOCK, locked_s=1 SHALL move the FSM to STABLE with the stable counter cleared.
REQ-017 In STABLE, the stable counter SHALL increment each cycle; at count LOCK_STABLE_CYC-1 the FSM SHALL move to RELEASE with channel index 0 and the gap counter at 0.
REQ-018 In RELEASE, rstn_o[idx] SHALL be set to 1 in the cycle the gap counter is 0.
REQ-019 In RELEASE, at gap count RST_GAP_CYC-1, idx SHALL increment; if idx was NUM_CH-1, the FSM SHALL move to RUN.
REQ-020 Consequently, rstn_o[k] SHALL rise exactly k*RST_GAP_CYC cycles after rstn_o[0].
REQ-021 In RUN, ready_o SHALL be 1 (registered, asserted the first RUN cycle); in every other state it SHALL be 0.
REQ-022 If locked_s=0 or sw_rst_i=1 in STABLE, RELEASE or RUN, then on the next edge the FSM SHALL enter WAIT_LOCK, and all rstn_o, clk_en_o, ready_o and counters SHALL clear in that same edge.
REQ-023 sw_rst_i=1 in WAIT_LOCK SHALL hold the FSM in WAIT_LOCK.
REQ-024 Per-channel divider: while rstn_o[k]=1, cnt[k] SHALL count 0..R-1 and wrap; clk_en_o[k] SHALL be high for exactly one cycle when cnt[k]==R-1, where R is ratio[k].
REQ-025 A ratio of 0 or 1 SHALL be treated as 1, giving clk_en_o[k]=1 every cycle while released.
REQ-026 While rstn_o[k]=0, cnt[k] SHALL be 0 and clk_en_o[k] SHALL be 0.
REQ-027 The first clk_en_o[k] pulse SHALL occur R cycles after rstn_o[k] rises.
REQ-028 cfg_load_i=1 SHALL capture all ratios at the edge and reset every cnt[k] to 0 on the same edge; the next pulse SHALL follow R_new cycles later.
REQ-029 cfg_load_i SHALL be accepted in any state.
REQ-030 If cfg_load_i coincides with lock loss or sw_rst_i, the ratios SHALL load and the reset/clear behaviour SHALL take priority for counters and outputs.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 sys_rst_i=1 SHALL asynchronously force: FSM=WAIT_LOCK, synchroniser flops=0, all counters=0, ratio registers=1, rstn_o=0, clk_en_o=0, ready_o=0.
REQ-033 Reset release SHALL be synchronous to sys_clk_i, with the first state evaluation on the first edge after deassertion.

Structure
REQ-034 A shared package clk_mgr_pkg SHALL hold the state enum clk_mgr_state_e and the default parameter constants.
REQ-035 The 2-flop synchroniser SHALL be a sub-module named bit_sync, with reset port sys_rst_i; everything else SHALL be inline in clk_en_rst_manager.

Verification
REQ-036 Scenario 1: defaults, pll_locked_i rises at cycle 10 -> rstn_o[0] rises 2+16+1 cycles later (±1, documented exactly in the bench); rstn_o[1..3] follow at +4, +8, +12 cycles; ready_o rises 4 cycles after rstn_o[3].
REQ-037 Scenario 2: ratios {1,2,5,0} loaded in RUN -> clk_en_o[0] constant 1; clk_en_o[1] high every 2nd cycle; clk_en_o[2] high every 5th cycle; clk_en_o[3] constant 1.
REQ-038 Scenario 3: pll_locked_i drops for 1 cycle during RELEASE with idx=2 -> after 2 sync cycles plus 1 edge, all rstn_o=0 and clk_en_o=0, FSM in WAIT_LOCK, and the full sequence restarts after relock.
REQ-039 Scenario 4: pll_locked_i glitches low at stable count 10 -> FSM returns to WAIT_LOCK, no rstn_o rises, and the stable count restarts from 0.
REQ-040 Scenario 5: sw_rst_i pulse in RUN together with cfg_load_i (ratio 3) -> all outputs clear next edge; after re-sequencing, clk_en_o[k] has period 3.
REQ-041 Scenario 6: sys_rst_i asserted mid-RUN asynchronously (between edges) -> outputs go 0 immediately without a clock edge; ratios return to 1.
